// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data SRAM arbiter.
package mem_arbiter_pkg;

  // Which requester's read data comes back from the SRAM this cycle
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INST,
    OWN_DATA
  } owner_t;

  // Width of the data-burst starvation counter (holds up to 15)
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous SRAM between instruction fetch and
// data load/store. Data has fixed priority. An instruction grant is forced
// once MAX_DATA_BURST consecutive data grants have been issued while a fetch
// was waiting. Read data returns one cycle after the grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction fetch port
  input  logic                  inst_req,
  input  logic [DATA_WIDTH-1:0] inst_addr,
  output logic                  inst_gnt,
  output logic                  inst_rvalid,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  // data load/store port
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [DATA_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_gnt,
  output logic                  data_rvalid,
  output logic [DATA_WIDTH-1:0] data_rdata,
  // SRAM macro port
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_w,
  input  logic [DATA_WIDTH-1:0] mem_r,
  output logic                  mem_csn,
  output logic                  mem_wen
);

  localparam logic [STARVE_CNT_W-1:0] BURST_LIMIT = STARVE_CNT_W'(MAX_DATA_BURST);

  owner_t                  owner;
  owner_t                  owner_nxt;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic [STARVE_CNT_W-1:0] starve_cnt_nxt;
  logic                    grant_inst;
  logic                    grant_data;

  // Grant selection: data wins contention unless the fetch has starved too long.
  // Requests seen while rst is high are ignored.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (!rst) begin
      if (inst_req && data_req) begin
        if (starve_cnt == BURST_LIMIT) grant_inst = 1'b1;
        else                           grant_data = 1'b1;
      end else if (inst_req) begin
        grant_inst = 1'b1;
      end else if (data_req) begin
        grant_data = 1'b1;
      end
    end
  end

  // Drive the SRAM from whichever requester was granted; idle bus is all-quiet.
  always_comb begin
    mem_csn     = 1'b1;
    mem_wen     = 1'b1;
    mem_address = '0;
    mem_w       = '0;
    if (grant_inst) begin
      mem_csn     = 1'b0;
      mem_address = inst_addr;
    end else if (grant_data) begin
      mem_csn     = 1'b0;
      mem_wen     = ~data_we;
      mem_address = data_addr;
      mem_w       = data_wdata;
    end
  end

  // Next owner of the returning read data and next starvation count.
  always_comb begin
    owner_nxt      = OWN_NONE;
    starve_cnt_nxt = starve_cnt;
    if (grant_inst)                 owner_nxt = OWN_INST;
    else if (grant_data && !data_we) owner_nxt = OWN_DATA;

    if (!inst_req || grant_inst) begin
      starve_cnt_nxt = '0;
    end else if (grant_data) begin
      starve_cnt_nxt = (starve_cnt == BURST_LIMIT) ? starve_cnt : starve_cnt + 1'b1;
    end
  end

  // ---- stage boundary: grant cycle -> read-return cycle ----
  // Owner and starvation counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      owner      <= owner_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Route returning SRAM data to its owner; a read in flight when reset rises is dropped.
  always_comb begin
    inst_gnt    = grant_inst;
    data_gnt    = grant_data;
    inst_rvalid = !rst && (owner == OWN_INST);
    data_rvalid = !rst && (owner == OWN_DATA);
    inst_rdata  = inst_rvalid ? mem_r : '0;
    data_rdata  = data_rvalid ? mem_r : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: an SRAM model, a reference
// arbiter/memory model, a cycle driver and an independent read-return monitor.
module tb_mem_arbiter;

  localparam int DW    = 32;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req, data_req, data_we;
  logic [DW-1:0] inst_addr, data_addr, data_wdata;
  logic          inst_gnt, inst_rvalid, data_gnt, data_rvalid;
  logic [DW-1:0] inst_rdata, data_rdata;
  logic [DW-1:0] mem_address, mem_w, mem_r;
  logic          mem_csn, mem_wen;

  mem_arbiter #(.DATA_WIDTH(DW), .MAX_DATA_BURST(BURST)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_address(mem_address), .mem_w(mem_w), .mem_r(mem_r),
    .mem_csn(mem_csn), .mem_wen(mem_wen)
  );

  always #5 clk = ~clk;

  // Environment SRAM: 256 words indexed by the low address byte.
  logic [DW-1:0] sram [256];
  always @(posedge clk) begin
    if (!mem_csn) begin
      if (!mem_wen) sram[mem_address[7:0]] <= mem_w;
      else          mem_r <= sram[mem_address[7:0]];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [256];
  int            run;          // data grants issued in a row while a fetch waited
  typedef struct { bit is_inst; logic [DW-1:0] data; } exp_t;
  exp_t          exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One bus cycle: drive inputs, predict grant and SRAM controls, check, update model.
  task automatic cycle(input bit r, input bit ir, input logic [DW-1:0] ia,
                       input bit dr, input bit dwe, input logic [DW-1:0] da,
                       input logic [DW-1:0] dwd, output bit ig, output bit dg);
    bit ei, ed;
    @(negedge clk);
    rst = r; inst_req = ir; inst_addr = ia;
    data_req = dr; data_we = dwe; data_addr = da; data_wdata = dwd;
    #2;
    ei = 0; ed = 0;
    if (!r) begin
      if (ir && dr) begin
        if (run == BURST) ei = 1; else ed = 1;
      end else begin
        ei = ir; ed = dr;
      end
      chk("starve_cnt", 32'(dut.starve_cnt), 32'(run));
    end
    chk("inst_gnt", 32'(inst_gnt), 32'(ei));
    chk("data_gnt", 32'(data_gnt), 32'(ed));
    chk("mem_csn", 32'(mem_csn), 32'(!(ei || ed)));
    chk("mem_wen", 32'(mem_wen), 32'(!(ed && dwe)));
    chk("mem_address", mem_address, ei ? ia : (ed ? da : '0));
    if (!ei) chk("mem_w", mem_w, ed ? dwd : '0);
    // model updates
    if (ei) exp_q.push_back('{1'b1, ref_mem[ia[7:0]]});
    if (ed && !dwe) exp_q.push_back('{1'b0, ref_mem[da[7:0]]});
    if (ed && dwe) ref_mem[da[7:0]] = dwd;
    if (r || !ir || ei) run = 0;
    else if (ed && run < BURST) run++;
    ig = inst_gnt; dg = data_gnt;
  endtask

  // Read-return monitor: each cycle compares rvalid/rdata against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        exp_q.delete();
        chk("rst_inst_rvalid", 32'(inst_rvalid), 0);
        chk("rst_data_rvalid", 32'(data_rvalid), 0);
        chk("rst_inst_rdata", inst_rdata, '0);
        chk("rst_data_rdata", data_rdata, '0);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("inst_rvalid", 32'(inst_rvalid), 32'(e.is_inst));
        chk("data_rvalid", 32'(data_rvalid), 32'(!e.is_inst));
        chk("inst_rdata", inst_rdata, e.is_inst ? e.data : '0);
        chk("data_rdata", data_rdata, e.is_inst ? '0 : e.data);
      end else begin
        chk("idle_inst_rvalid", 32'(inst_rvalid), 0);
        chk("idle_data_rvalid", 32'(data_rvalid), 0);
        chk("idle_inst_rdata", inst_rdata, '0);
        chk("idle_data_rdata", data_rdata, '0);
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    bit ig, dg;
    bit i_pend, d_pend, d_we_r;
    logic [DW-1:0] ia_r, da_r, dwd_r;
    int grant_seq[$];

    rst = 1; inst_req = 0; data_req = 0; data_we = 0;
    inst_addr = '0; data_addr = '0; data_wdata = '0;
    run = 0;
    for (int i = 0; i < 256; i++) begin
      sram[i] = $urandom;
      ref_mem[i] = sram[i];
    end
    sram[8'h10] = 32'hDEADBEEF;
    ref_mem[8'h10] = 32'hDEADBEEF;

    // reset with requests present (ignored)
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'h10, 1, 0, 32'h20, 0, ig, dg);

    // fetch only
    cycle(0, 1, 32'h10, 0, 0, 0, 0, ig, dg);
    cycle(0, 0, 0, 0, 0, 0, 0, ig, dg);

    // store then load
    cycle(0, 0, 0, 1, 1, 32'h40, 32'h12345678, ig, dg);
    cycle(0, 0, 0, 1, 0, 32'h40, 0, ig, dg);
    cycle(0, 0, 0, 0, 0, 0, 0, ig, dg);
    chk("store_load_mem", ref_mem[8'h40], 32'h12345678);

    // contention: expect D,D,D,D,I repeating
    for (int i = 0; i < 15; i++) begin
      cycle(0, 1, 32'(i), 1, 0, 32'(i + 100), 0, ig, dg);
      grant_seq.push_back(ig ? 1 : 0);
    end
    for (int i = 0; i < 15; i++)
      chk("contention_pattern", 32'(grant_seq[i]), 32'((i % 5) == 4));

    // alternating owners I, D(load), I
    cycle(0, 1, 32'h10, 0, 0, 0, 0, ig, dg);
    cycle(0, 0, 0, 1, 0, 32'h40, 0, ig, dg);
    cycle(0, 1, 32'h11, 0, 0, 0, 0, ig, dg);
    cycle(0, 0, 0, 0, 0, 0, 0, ig, dg);

    // reset mid-read
    cycle(0, 0, 0, 1, 0, 32'h40, 0, ig, dg);
    cycle(1, 0, 0, 1, 0, 32'h40, 0, ig, dg);
    cycle(1, 0, 0, 0, 0, 0, 0, ig, dg);

    // idle
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0, 0, 0, ig, dg);

    // randomized traffic honouring the hold-until-grant rule
    i_pend = 0; d_pend = 0; ia_r = '0; da_r = '0; dwd_r = '0; d_we_r = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!i_pend) begin
        i_pend = ($urandom % 4) != 0;
        ia_r = 32'($urandom_range(0, 255));
      end
      if (!d_pend) begin
        d_pend = ($urandom % 3) != 0;
        da_r = 32'($urandom_range(0, 255));
        d_we_r = $urandom % 2;
        dwd_r = $urandom;
      end
      cycle(($urandom % 200) == 0, i_pend, ia_r, d_pend, d_we_r, da_r, dwd_r, ig, dg);
      if (ig) i_pend = 0;
      if (dg) d_pend = 0;
    end

    cycle(0, 0, 0, 0, 0, 0, 0, ig, dg);
    cycle(0, 0, 0, 0, 0, 0, 0, ig, dg);
    @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-port synchronous SRAM between the core's instruction-fetch port and data load/store port, so a unified memory can replace the separate instruction and data memories. Grants at most one request per cycle with a req/gnt handshake and returns read data one cycle later with a valid strobe. Data accesses have fixed priority. A starvation counter forces an instruction grant after a bounded run of data grants. The block sits between `core` and the memory macro.

## Interface
- `DATA_WIDTH`, 32, address and data width for all ports
- `MAX_DATA_BURST`, 4, consecutive data grants allowed while `inst_req` is pending before instruction is forced; range 1..15
- `clk` in 1: single clock, all state on posedge
- `rst` in 1: synchronous, active-high reset
- `inst_req` in 1: fetch request
- `inst_addr` in DATA_WIDTH: fetch address
- `inst_gnt` out 1: fetch accepted this cycle
- `inst_rvalid` out 1: `inst_rdata` valid
- `inst_rdata` out DATA_WIDTH: fetched word
- `data_req` in 1: load/store request
- `data_we` in 1: 1 = store, 0 = load
- `data_addr` in DATA_WIDTH: access address
- `data_wdata` in DATA_WIDTH: store data
- `data_gnt` out 1: access accepted this cycle
- `data_rvalid` out 1: `data_rdata` valid (loads only)
- `data_rdata` out DATA_WIDTH: load data
- `mem_address` out DATA_WIDTH: SRAM address
- `mem_w` out DATA_WIDTH: SRAM write data
- `mem_r` in DATA_WIDTH: SRAM read data, valid the cycle after an enabled read
- `mem_csn` out 1: SRAM chip select, active-low
- `mem_wen` out 1: SRAM write enable, active-low

## Operation
- Grant decision is combinational each cycle from `inst_req`, `data_req` and `starve_cnt`. `starve_cnt` is a 4-bit register.
- Selection rule:
  - only one requester active: that requester is granted;
  - both active and `starve_cnt == MAX_DATA_BURST`: instruction is granted;
  - both active otherwise: data is granted;
  - neither active: no grant.
- Memory signals when a grant is issued:
  - `mem_csn` = 0.
  - `mem_address` = granted address.
  - Instruction grant: `mem_wen` = 1.
  - Data grant: `mem_wen` = `~data_we`, `mem_w` = `data_wdata`.
- With no grant: `mem_csn` = 1, `mem_wen` = 1, `mem_address` = 0, `mem_w` = 0.
- `owner` register (`OWN_NONE`/`OWN_INST`/`OWN_DATA`) records which requester received a read grant last cycle. It is set to `OWN_NONE` for stores and for cycles with no grant.
- Read data return:
  - `inst_rvalid` = (`owner` == `OWN_INST`); `data_rvalid` = (`owner` == `OWN_DATA`).
  - `*_rdata` = `mem_r` when the matching rvalid is 1, else 0.
- `starve_cnt` update, evaluated in this order:
  - `inst_req` low or instruction granted: 0;
  - data granted while `inst_req` high: increment, saturating at `MAX_DATA_BURST`;
  - otherwise: hold.
- Requester rule: a requester holds req/addr/we/wdata stable until it sees gnt. After gnt it may present a new request in the next cycle.
- Addresses pass through untranslated. No byte-lane handling.

## Timing
- Grant latency is 0 cycles: `gnt` is asserted in the same cycle as `req` when that requester is selected.
- Read latency is 1 cycle: `rvalid` is high in the cycle after `gnt`, exactly one cycle long.
- Throughput is one access per cycle. Back-to-back grants, including alternating owners, are legal. `rvalid` for grant N overlaps `gnt` for grant N+1.
- Stores produce no rvalid. Store completes at the posedge ending the grant cycle.
- Reset values, while `rst` is high:
  - both `gnt` = 0, both `rvalid` = 0, both `rdata` = 0;
  - `mem_csn` = 1, `mem_wen` = 1, `mem_address` = 0, `mem_w` = 0;
  - `owner` = `OWN_NONE`, `starve_cnt` = 0.
- Reset mid-operation: a read granted in the cycle before `rst` rises is discarded. No rvalid appears in or after the reset cycle.
- Requests present during `rst` are ignored. They are considered from the first cycle with `rst` low.

## Structure
- Package `mem_arbiter_pkg` holds:
  - `typedef enum logic [1:0] owner_t {OWN_NONE, OWN_INST, OWN_DATA}`;
  - `STARVE_CNT_W` = 4.
- Single module, no sub-module: the grant logic, `owner` register and starvation counter are small enough to keep flat.

## Test plan
- Fetch only: `inst_req`=1, `inst_addr`=0x10, SRAM holds 0xDEADBEEF at 0x10 -> `inst_gnt`=1, `mem_csn`=0, `mem_wen`=1 same cycle; next cycle `inst_rvalid`=1, `inst_rdata`=0xDEADBEEF.
- Store then load: store 0x12345678 to 0x40 (`data_we`=1), next cycle load 0x40 -> `mem_wen`=0 in cycle 0, no `data_rvalid` in cycle 1, `data_rvalid`=1 with 0x12345678 in cycle 2.
- Contention: both requesting continuously, `MAX_DATA_BURST`=4 -> grant pattern D,D,D,D,I repeating; `starve_cnt` returns to 0 after each I.
- Alternating owners: grants I,D(load),I back-to-back -> rvalid strobes follow on exactly I,D,I one cycle later; no cross-delivery of rdata.
- Reset mid-read: load granted in cycle N, `rst`=1 in cycle N+1 -> `data_rvalid`=0 in N+1 and N+2; `mem_csn`=1 during reset.
- Idle: no requests for 10 cycles -> `mem_csn`=1, `mem_address`=0, all gnt/rvalid 0, `starve_cnt`=0.
